// File: rtl/spi_frame_pkg.sv
// Shared frame definitions for the DIN/CIN channel-value link.
// Used by spiwriter and spireader; SPIWRITER_PARITY_EN adds a parity bit.
package spi_frame_pkg;

   localparam int unsigned FRAME_ADDR_W = 3;
   localparam int unsigned FRAME_DATA_W = 16;

`ifdef SPIWRITER_PARITY_EN
   localparam int unsigned FRAME_BITS = FRAME_ADDR_W + FRAME_DATA_W + 1;
`else
   localparam int unsigned FRAME_BITS = FRAME_ADDR_W + FRAME_DATA_W;
`endif

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_SHIFT = 2'd1,
      TX_GAP   = 2'd2
   } spi_tx_state_t;

   // Frame image, MSB transmitted first.
   function automatic logic [FRAME_BITS-1:0] frame_pack(
      input logic [FRAME_ADDR_W-1:0] addr,
      input logic [FRAME_DATA_W-1:0] value
   );
`ifdef SPIWRITER_PARITY_EN
      // Even parity: the appended bit makes the total count of ones even.
      return {addr, value, ^{addr, value}};
`else
      return {addr, value};
`endif
   endfunction

endpackage

// File: rtl/spi_bitclock.sv
// Bit-period generator: divider counter, cout level, rise/fall ticks.
// Ports: clk_i, rst_i (sync, high), run_i; cout_o, rise_tick_o, fall_tick_o.
module spi_bitclock
   import spi_frame_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic cout_o,
   output logic rise_tick_o,
   output logic fall_tick_o
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          high_q, high_d;
   logic          wrap;

   assign wrap = (cnt_q == LAST);

   always_comb begin
      cnt_d  = cnt_q;
      high_d = high_q;
      if (!run_i) begin
         cnt_d  = '0;
         high_d = 1'b0;
      end else if (wrap) begin
         cnt_d  = '0;
         high_d = ~high_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         high_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         high_q <= high_d;
      end
   end

   // rise: last cycle of the low phase; fall: last cycle of the high phase.
   assign rise_tick_o = run_i & wrap & ~high_q;
   assign fall_tick_o = run_i & wrap & high_q;
   assign cout_o      = run_i & high_q;

endmodule

// File: rtl/spiwriter.sv
// Serial frame transmitter: {address,data} MSB first on dout/cout + idle gap.
// Ports: clock, reset, data, address, valid -> ready, dout, cout, busy.
// Build option SPIWRITER_PARITY_EN appends an even-parity bit.
module spiwriter
   import spi_frame_pkg::*;
#(
   parameter int unsigned CLOCK_DIVIDER = 4,
   parameter int unsigned GAP_BITS      = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [FRAME_DATA_W-1:0] data,
   input  logic [FRAME_ADDR_W-1:0] address,
   input  logic                    valid,
   output logic                    ready,
   output logic                    dout,
   output logic                    cout,
   output logic                    busy
);

   localparam int unsigned GAP_CYC = GAP_BITS * 2 * CLOCK_DIVIDER;
   localparam int unsigned GW      = $clog2(GAP_CYC);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
   localparam logic [4:0]    ALL_BITS = 5'(FRAME_BITS);

   spi_tx_state_t         state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [4:0]            bit_q, bit_d;
   logic [GW-1:0]         gap_q, gap_d;

   logic run;
   logic bc_cout;
   logic rise_tick;
   logic fall_tick;

   assign run = (state_q == TX_SHIFT);

   spi_bitclock #(
      .DIV (CLOCK_DIVIDER)
   ) u_bitclock (
      .clk_i       (clock),
      .rst_i       (reset),
      .run_i       (run),
      .cout_o      (bc_cout),
      .rise_tick_o (rise_tick),
      .fall_tick_o (fall_tick)
   );

   // bit_q counts bits the receiver has already sampled (cout rises),
   // so the frame is complete at the fall tick after the last rise.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      unique case (state_q)
         TX_IDLE: begin
            if (valid) begin
               shift_d = frame_pack(address, data);
               bit_d   = '0;
               state_d = TX_SHIFT;
            end
         end
         TX_SHIFT: begin
            if (rise_tick) begin
               bit_d = bit_q + 5'd1;
            end
            if (fall_tick) begin
               if (bit_q == ALL_BITS) begin
                  gap_d   = '0;
                  state_d = TX_GAP;
               end else begin
                  shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
               end
            end
         end
         TX_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = TX_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= TX_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
      end
   end

   // Outputs are forced to their idle values for as long as reset is high.
   assign ready = (state_q == TX_IDLE) & ~reset;
   assign busy  = (state_q != TX_IDLE) & ~reset;
   assign dout  = run & shift_q[FRAME_BITS-1] & ~reset;
   assign cout  = bc_cout & ~reset;

endmodule

// File: tb/tb_spiwriter.sv
// Self-checking bench for spiwriter: a behavioural receiver samples dout
// on cout rises and frame timing is compared against the link rules.
module tb_spiwriter;

`ifdef SPIWRITER_PARITY_EN
   localparam int NB = 20;
`else
   localparam int NB = 19;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data;
   logic [2:0]  addr;
   logic        vd, vf;
   logic        rd_d, dout_d, cout_d, busy_d;
   logic        rd_f, dout_f, cout_f, busy_f;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spiwriter #(
      .CLOCK_DIVIDER (4),
      .GAP_BITS      (4)
   ) u_dut (
      .clock   (clk),
      .reset   (rst),
      .data    (data),
      .address (addr),
      .valid   (vd),
      .ready   (rd_d),
      .dout    (dout_d),
      .cout    (cout_d),
      .busy    (busy_d)
   );

   spiwriter #(
      .CLOCK_DIVIDER (1),
      .GAP_BITS      (2)
   ) u_fast (
      .clock   (clk),
      .reset   (rst),
      .data    (data),
      .address (addr),
      .valid   (vf),
      .ready   (rd_f),
      .dout    (dout_f),
      .cout    (cout_f),
      .busy    (busy_f)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected frame as a bit string: address, data, optional even parity.
   function automatic logic [19:0] exp_frame(input logic [2:0] a,
                                             input logic [15:0] v);
      logic [19:0] w;
      int ones;
      w = {1'b0, a, v};
      ones = 0;
      for (int i = 0; i < 19; i++) ones += int'(w[i]);
      if (NB == 20) w = {a, v, 1'(ones % 2)};
      return w;
   endfunction

   task automatic sample(input bit sel, output logic c, output logic d,
                         output logic b, output logic r);
      c = sel ? cout_f : cout_d;
      d = sel ? dout_f : dout_d;
      b = sel ? busy_f : busy_d;
      r = sel ? rd_f   : rd_d;
   endtask

   task automatic set_valid(input bit sel, input logic v);
      if (sel) vf = v;
      else     vd = v;
   endtask

   // Entered at a negedge with the transmitter idle; the next posedge
   // accepts. Runs until ready returns (bounded) and checks the frame.
   task automatic send(input bit sel, input int cd, input int gb,
                       input logic [2:0] a, input logic [15:0] v,
                       input bit keep, input logic [2:0] na,
                       input logic [15:0] nv, output logic [19:0] got);
      logic [19:0] ew;
      logic c, d, b, r, pc, d_rise;
      int rises, first_rise, last_high, n_ready, unstable, busy_gap, hi;
      ew = exp_frame(a, v);
      sample(sel, c, d, b, r);
      chk("ready_before_accept", r, 1);
      addr = a;
      data = v;
      set_valid(sel, 1'b1);
      got = '0;
      pc = 1'b0;
      d_rise = 1'b0;
      rises = 0;
      first_rise = -1;
      last_high = -1;
      n_ready = -1;
      unstable = 0;
      busy_gap = 0;
      hi = 0;
      for (int n = 1; n <= 600; n++) begin
         @(negedge clk);
         sample(sel, c, d, b, r);
         if (n == 1) begin
            chk("start_dout", d, ew[NB-1]);
            chk("start_cout", c, 0);
            chk("start_busy", b, 1);
            if (keep) begin
               addr = na;
               data = nv;
            end else begin
               set_valid(sel, 1'b0);
            end
         end
         if (r) begin
            n_ready = n;
            chk("busy_at_ready", b, 0);
            break;
         end
         if (!b) busy_gap++;
         if (c) begin
            hi++;
            last_high = n;
            if (!pc) begin
               rises++;
               if (first_rise < 0) first_rise = n;
               got = {got[18:0], d};
               d_rise = d;
            end else if (d !== d_rise) begin
               unstable++;
            end
         end
         pc = c;
      end
      chk("ready_time", n_ready, 1 + 2 * cd * NB + 2 * cd * gb);
      chk("rise_count", rises, NB);
      chk("first_rise", first_rise, 1 + cd);
      chk("frame_bits", got, ew);
      chk("frame_end", last_high + 1, 1 + 2 * cd * NB);
      chk("dout_stable", unstable, 0);
      chk("busy_gap", busy_gap, 0);
      chk("high_cycles", hi, NB * cd);
   endtask

   logic [19:0] got;
   logic [15:0] rv;

   initial begin
      rst = 1'b1;
      vd = 1'b0;
      vf = 1'b0;
      addr = '0;
      data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", rd_d, 0);
      chk("rst_busy", busy_d, 0);
      chk("rst_cout", cout_d, 0);
      chk("rst_dout", dout_d, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", rd_d, 1);
      chk("post_rst_ready_fast", rd_f, 1);
      chk("post_rst_busy", busy_d, 0);

      send(1'b0, 4, 4, 3'd5, 16'hA5C3, 1'b0, 3'd0, 16'h0, got);
      chk("a5c3_prefix", got[NB-1 -: 19], 19'b1011010010111000011);

      // valid held high across two words
      send(1'b0, 4, 4, 3'd0, 16'h0001, 1'b1, 3'd7, 16'hFFFF, got);
      send(1'b0, 4, 4, 3'd7, 16'hFFFF, 1'b0, 3'd0, 16'h0, got);

      rv = 16'($urandom);
      send(1'b1, 1, 2, 3'd3, rv, 1'b0, 3'd0, 16'h0, got);

      // reset during bit 9 (cycles 73..80 of the frame)
      addr = 3'd6;
      data = 16'($urandom);
      vd = 1'b1;
      @(negedge clk);
      vd = 1'b0;
      repeat (75) @(negedge clk);
      chk("mid_busy", busy_d, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_cout", cout_d, 0);
      chk("abort_dout", dout_d, 0);
      chk("abort_busy", busy_d, 0);
      chk("abort_ready", rd_d, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready_after", rd_d, 1);
      chk("abort_busy_after", busy_d, 0);

      for (int a = 0; a < 8; a++) begin
         rv = 16'($urandom);
         send(1'b0, 4, 4, 3'(a), rv, 1'b0, 3'd0, 16'h0, got);
      end

`ifdef SPIWRITER_PARITY_EN
      send(1'b0, 4, 4, 3'd0, 16'h0001, 1'b0, 3'd0, 16'h0, got);
      chk("parity_one", got[0], 1);
      send(1'b0, 4, 4, 3'd0, 16'h0003, 1'b0, 3'd0, 16'h0, got);
      chk("parity_zero", got[0], 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
